frame_display_ctrl: RTL and testbench

Parametrised display/run controller for the filter system; the next generation of the fixed-resolution VGA top. It runs on the 25 MHz pixel clock and does four jobs:
- generates VGA timing, with the resolution set by parameters;
- fetches the filtered image from image memory, with integer pixel replication and centred placement;
- produces the processor clock-enable;
- detects the processor halt word and uses it to freeze the processor and release the display.

Output modes (grey / invert / threshold / test bars) are selectable and only take effect at frame boundaries.

---
 rtl/frame_display_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_frame_display_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_display_ctrl.sv
// frame_display_ctrl: VGA timing generator, image fetch, output colour stage and processor
// run control for the filter system. Runs on the pixel clock.
//   clk, reset     pixel clock, asynchronous active-low reset
//   instr          current processor instruction (compared only on proc_ce cycles)
//   mode, thr      output mode and threshold level, latched at the first pixel of each frame
//   mem_data       image memory read data, valid MEM_LAT cycles after mem_addr
//   mem_addr       image memory read address (registered, holds outside the image window)
//   proc_ce        one-cycle processor clock-enable every CE_DIV cycles, stops once halted
//   halted         sticky halt flag
//   vga_hs/vga_vs  active-low syncs; vga_blank is high while visible
//   r_out/g_out/b_out colour outputs; frame_cnt counts completed frames
module frame_display_ctrl #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned IMG_W     = 256,
   parameter int unsigned IMG_H     = 256,
   parameter int unsigned SCALE     = 1,
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MEM_LAT   = 1,
   parameter int unsigned CE_DIV    = 4,
   parameter logic [31:0] HALT_WORD = 32'h9EFFFFFE,
   parameter int unsigned LIVE_VIEW = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instr,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] thr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              proc_ce,
   output logic              halted,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank,
   output logic [DATA_W-1:0] r_out,
   output logic [DATA_W-1:0] g_out,
   output logic [DATA_W-1:0] b_out,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW    = $clog2(H_TOT);
   localparam int unsigned VW    = $clog2(V_TOT);
   localparam int unsigned SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int unsigned CW    = $clog2(CE_DIV);
   localparam int unsigned PIPE  = MEM_LAT + 1;
   localparam int unsigned X0    = (H_ACTIVE - IMG_W * SCALE) / 2;
   localparam int unsigned Y0    = (V_ACTIVE - IMG_H * SCALE) / 2;

   localparam logic [HW-1:0]     H_LAST  = HW'(H_TOT - 1);
   localparam logic [HW-1:0]     H_ACT   = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     HS_BEG  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0]     X_BEG   = HW'(X0);
   localparam logic [HW-1:0]     X_END   = HW'(X0 + IMG_W * SCALE);
   localparam logic [HW:0]       BAR_TOP = (HW + 1)'(H_ACTIVE);
   localparam logic [VW-1:0]     V_LAST  = VW'(V_TOT - 1);
   localparam logic [VW-1:0]     V_ACT   = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     VS_BEG  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0]     Y_BEG   = VW'(Y0);
   localparam logic [VW-1:0]     Y_END   = VW'(Y0 + IMG_H * SCALE);
   localparam logic [SW-1:0]     S_LAST  = SW'(SCALE - 1);
   localparam logic [CW-1:0]     CE_LAST = CW'(CE_DIV - 1);
   localparam logic [ADDR_W-1:0] LINE_W  = ADDR_W'(IMG_W);
   // Pipe word: {hs, vs, vis, in_img, bar[2:0]}; reset keeps syncs inactive.
   localparam logic [6:0]        PIPE_RST = 7'b1100000;

   logic [HW-1:0]     hc_q, hc_d, bar_acc_q, bar_acc_d;
   logic [VW-1:0]     vc_q, vc_d;
   logic [15:0]       frame_q, frame_d;
   logic [ADDR_W-1:0] col_q, col_d, base_q, base_d, addr_q, addr_d;
   logic [SW-1:0]     rep_q, rep_d, lrep_q, lrep_d;
   logic [2:0]        bar_idx_q, bar_idx_d;
   logic [CW-1:0]     ce_cnt_q, ce_cnt_d;
   logic              halted_q, halted_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] thr_q, thr_d;
   logic [6:0]        pipe_q [PIPE];
   logic [6:0]        pipe_d [PIPE];
   logic              hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
   logic [DATA_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

   logic              line_end, in_x, in_y, vis_raw, in_img, hs_raw, vs_raw;
   logic [HW:0]       bar_sum;
   logic [6:0]        tap;
   logic [DATA_W-1:0] pix;

   assign proc_ce = (ce_cnt_q == CE_LAST) && !halted_q;

   // Counters, address generation, run control and the alignment pipe.
   always_comb begin
      line_end = (hc_q == H_LAST);
      in_x     = (hc_q >= X_BEG) && (hc_q < X_END);
      in_y     = (vc_q >= Y_BEG) && (vc_q < Y_END);
      vis_raw  = (hc_q < H_ACT) && (vc_q < V_ACT);
      in_img   = vis_raw && in_x && in_y;
      hs_raw   = !((hc_q >= HS_BEG) && (hc_q < HS_END));
      vs_raw   = !((vc_q >= VS_BEG) && (vc_q < VS_END));

      hc_d    = line_end ? '0 : hc_q + 1'b1;
      vc_d    = vc_q;
      frame_d = frame_q;
      if (line_end) begin
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
         if (vc_q == V_LAST) frame_d = frame_q + 16'd1;
      end

      // Column advances every SCALE pixels inside the window, restarts outside it.
      col_d = col_q;
      rep_d = rep_q;
      if (!in_x) begin
         col_d = '0;
         rep_d = '0;
      end else if (rep_q == S_LAST) begin
         rep_d = '0;
         col_d = col_q + 1'b1;
      end else begin
         rep_d = rep_q + 1'b1;
      end

      // Line base advances by one image row every SCALE window lines.
      base_d = base_q;
      lrep_d = lrep_q;
      if (line_end) begin
         if (!in_y) begin
            base_d = '0;
            lrep_d = '0;
         end else if (lrep_q == S_LAST) begin
            lrep_d = '0;
            base_d = base_q + LINE_W;
         end else begin
            lrep_d = lrep_q + 1'b1;
         end
      end

      addr_d = in_img ? base_q + col_q : addr_q;

      // bar_idx = hc*8/H_ACTIVE, tracked as quotient plus remainder.
      bar_sum   = {1'b0, bar_acc_q} + (HW + 1)'(8);
      bar_acc_d = bar_acc_q;
      bar_idx_d = bar_idx_q;
      if (line_end) begin
         bar_acc_d = '0;
         bar_idx_d = '0;
      end else if (hc_q < H_ACT) begin
         if (bar_sum >= BAR_TOP) begin
            bar_acc_d = bar_sum[HW-1:0] - H_ACT;
            bar_idx_d = bar_idx_q + 3'd1;
         end else begin
            bar_acc_d = bar_sum[HW-1:0];
         end
      end

      ce_cnt_d = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + 1'b1;
      halted_d = halted_q || (proc_ce && (instr == HALT_WORD));

      mode_d = mode_q;
      thr_d  = thr_q;
      if ((hc_q == '0) && (vc_q == '0)) begin
         mode_d = mode;
         thr_d  = thr;
      end

      pipe_d[0] = {hs_raw, vs_raw, vis_raw, in_img, bar_idx_q};
      for (int i = 1; i < PIPE; i++) pipe_d[i] = pipe_q[i-1];
   end

   // Output stage: tap is aligned with mem_data for the same pixel.
   always_comb begin
      tap     = pipe_q[PIPE-1];
      hs_d    = tap[6];
      vs_d    = tap[5];
      blank_d = tap[4];
      unique case (mode_q)
         2'b01:   pix = ~mem_data;
         2'b10:   pix = (mem_data >= thr_q) ? '1 : '0;
         default: pix = mem_data;
      endcase
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (tap[4]) begin
         if (mode_q == 2'b11) begin
            r_d = {DATA_W{~tap[1]}};
            g_d = {DATA_W{~tap[2]}};
            b_d = {DATA_W{~tap[0]}};
         end else if (tap[3] && (halted_q || (LIVE_VIEW != 0))) begin
            r_d = pix;
            g_d = pix;
            b_d = pix;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hc_q      <= '0;
         vc_q      <= '0;
         frame_q   <= '0;
         col_q     <= '0;
         rep_q     <= '0;
         base_q    <= '0;
         lrep_q    <= '0;
         addr_q    <= '0;
         bar_acc_q <= '0;
         bar_idx_q <= '0;
         ce_cnt_q  <= '0;
         halted_q  <= 1'b0;
         mode_q    <= 2'b00;
         thr_q     <= '0;
         for (int i = 0; i < PIPE; i++) pipe_q[i] <= PIPE_RST;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_q   <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else begin
         hc_q      <= hc_d;
         vc_q      <= vc_d;
         frame_q   <= frame_d;
         col_q     <= col_d;
         rep_q     <= rep_d;
         base_q    <= base_d;
         lrep_q    <= lrep_d;
         addr_q    <= addr_d;
         bar_acc_q <= bar_acc_d;
         bar_idx_q <= bar_idx_d;
         ce_cnt_q  <= ce_cnt_d;
         halted_q  <= halted_d;
         mode_q    <= mode_d;
         thr_q     <= thr_d;
         for (int i = 0; i < PIPE; i++) pipe_q[i] <= pipe_d[i];
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         blank_q   <= blank_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign mem_addr  = addr_q;
   assign halted    = halted_q;
   assign vga_hs    = hs_q;
   assign vga_vs    = vs_q;
   assign vga_blank = blank_q;
   assign r_out     = r_q;
   assign g_out     = g_q;
   assign b_out     = b_q;
   assign frame_cnt = frame_q;

endmodule

// File: tb/tb_frame_display_ctrl.sv
// Directed bench for frame_display_ctrl on a reduced raster (80x56 total, 64x48 visible).
// dut_a: 16x16 image, SCALE=1, LIVE_VIEW=0 (window x24..39, y16..31).
// dut_b: 16x16 image, SCALE=2, LIVE_VIEW=1 (window x16..47, y8..39).
// Pixel (x,y) of frame f is counter cycle c = f*4480 + y*80 + x; its address is on mem_addr
// after edge c+1 and its colour/sync on the pins after edge c+3.
module tb_frame_display_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic [1:0]  mode_a, mode_b;
   logic [7:0]  thr;
   logic [7:0]  mem_a_data, mem_b_data;
   logic        mem_a_const;
   logic [18:0] mem_a_addr, mem_b_addr;
   logic        proc_ce_a, proc_ce_b, halted_a, halted_b;
   logic        hs_a, hs_b, vs_a, vs_b, blank_a, blank_b;
   logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic [15:0] frame_a, frame_b;

   int unsigned ecnt;
   int          n_tests;
   int          n_fail;

   frame_display_ctrl #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
      .IMG_W(16), .IMG_H(16), .SCALE(1), .MEM_LAT(1), .CE_DIV(4), .LIVE_VIEW(0)
   ) dut_a (
      .clk(clk), .reset(reset), .instr(instr), .mode(mode_a), .thr(thr),
      .mem_data(mem_a_data), .mem_addr(mem_a_addr), .proc_ce(proc_ce_a), .halted(halted_a),
      .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank(blank_a),
      .r_out(r_a), .g_out(g_a), .b_out(b_a), .frame_cnt(frame_a)
   );

   frame_display_ctrl #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
      .IMG_W(16), .IMG_H(16), .SCALE(2), .MEM_LAT(1), .CE_DIV(4), .LIVE_VIEW(1)
   ) dut_b (
      .clk(clk), .reset(reset), .instr(32'h0), .mode(mode_b), .thr(8'h00),
      .mem_data(mem_b_data), .mem_addr(mem_b_addr), .proc_ce(proc_ce_b), .halted(halted_b),
      .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank(blank_b),
      .r_out(r_b), .g_out(g_b), .b_out(b_b), .frame_cnt(frame_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle-latency memories: data = low address byte, or a constant for dut_a.
   always @(posedge clk) begin
      mem_a_data <= mem_a_const ? 8'h30 : mem_a_addr[7:0];
      mem_b_data <= mem_b_addr[7:0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after edge k counted from reset release.
   task automatic goto(input int unsigned k);
      while (ecnt < k) begin
         @(posedge clk);
         ecnt++;
      end
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      ecnt = 0;
      reset = 1'b0;
      instr = 32'h0;
      mode_a = 2'b00;
      mode_b = 2'b00;
      thr = 8'h00;
      mem_a_const = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hs", {31'b0, hs_a}, 1);
      chk("rst_vs", {31'b0, vs_a}, 1);
      chk("rst_blank", {31'b0, blank_a}, 0);
      chk("rst_rgb", {8'h0, r_a, g_a, b_a}, 0);
      chk("rst_frame", {16'h0, frame_a}, 0);
      chk("rst_halted", {31'b0, halted_a}, 0);
      chk("rst_ce", {31'b0, proc_ce_a}, 0);
      chk("rst_addr", {13'b0, mem_a_addr}, 0);
      @(negedge clk);
      reset = 1'b1;
      ecnt = 0;

      // Enable pulses and a halt word that never coincides with one.
      goto(2);
      chk("ce_e2", {31'b0, proc_ce_a}, 0);
      chk("blank_e2", {31'b0, blank_a}, 0);
      chk("hs_e2", {31'b0, hs_a}, 1);
      goto(3);
      chk("ce_e3", {31'b0, proc_ce_a}, 1);
      chk("ce_b_e3", {31'b0, proc_ce_b}, 1);
      chk("blank_e3", {31'b0, blank_a}, 1);
      goto(4);
      chk("ce_e4", {31'b0, proc_ce_a}, 0);
      instr = 32'h9EFFFFFE;
      goto(6);
      instr = 32'h0;
      goto(7);
      chk("ce_e7", {31'b0, proc_ce_a}, 1);
      goto(9);
      chk("halt_between", {31'b0, halted_a}, 0);

      // Horizontal timing: hs low for hc 68..75, line period 80.
      goto(66);
      chk("blank_e66", {31'b0, blank_a}, 1);
      goto(67);
      chk("blank_e67", {31'b0, blank_a}, 0);
      goto(70);
      chk("hs_e70", {31'b0, hs_a}, 1);
      goto(71);
      chk("hs_e71", {31'b0, hs_a}, 0);
      chk("hs_b_e71", {31'b0, hs_b}, 0);
      goto(78);
      chk("hs_e78", {31'b0, hs_a}, 0);
      goto(79);
      chk("hs_e79", {31'b0, hs_a}, 1);
      goto(150);
      chk("hs_e150", {31'b0, hs_a}, 1);
      goto(151);
      chk("hs_e151", {31'b0, hs_a}, 0);

      // dut_b replication: address 0 for x16,17 then 1 for x18; rows 8,9 share a base.
      goto(657);
      chk("b_addr_x16", {13'b0, mem_b_addr}, 0);
      goto(658);
      chk("b_addr_x17", {13'b0, mem_b_addr}, 0);
      chk("b_r_x15", {24'b0, r_b}, 0);
      goto(659);
      chk("b_addr_x18", {13'b0, mem_b_addr}, 1);
      goto(660);
      chk("b_r_x17", {24'b0, r_b}, 0);
      goto(661);
      chk("b_r_x18", {24'b0, r_b}, 1);
      goto(739);
      chk("b_addr_y9", {13'b0, mem_b_addr}, 1);
      goto(819);
      chk("b_addr_y10", {13'b0, mem_b_addr}, 17);
      goto(821);
      chk("b_r_y10", {24'b0, r_b}, 32'h11);

      // dut_a image gated before halt.
      goto(1307);
      chk("a_gate_x24", {24'b0, r_a}, 0);
      goto(1308);
      chk("a_gate_x25", {24'b0, r_a}, 0);
      chk("a_blank_x25", {31'b0, blank_a}, 1);

      // Halt on an enable cycle.
      goto(2003);
      chk("halt_pre", {31'b0, halted_a}, 0);
      chk("ce_e2003", {31'b0, proc_ce_a}, 1);
      instr = 32'h9EFFFFFE;
      goto(2004);
      chk("halt_set", {31'b0, halted_a}, 1);
      chk("ce_e2004", {31'b0, proc_ce_a}, 0);
      goto(2007);
      chk("ce_frozen1", {31'b0, proc_ce_a}, 0);
      goto(2011);
      chk("ce_frozen2", {31'b0, proc_ce_a}, 0);
      chk("halted_b", {31'b0, halted_b}, 0);

      // Image released after halt, row 26 = image row 10.
      goto(2105);
      chk("a_addr_r10", {13'b0, mem_a_addr}, 160);
      goto(2106);
      chk("a_r_x23", {24'b0, r_a}, 0);
      goto(2107);
      chk("a_r_x24", {24'b0, r_a}, 32'hA0);
      goto(2108);
      chk("a_r_x25", {24'b0, r_a}, 32'hA1);
      goto(2520);
      chk("a_addr_last", {13'b0, mem_a_addr}, 255);
      goto(2522);
      chk("a_rgb_last", {8'h0, r_a, g_a, b_a}, 32'hFFFFFF);
      goto(3168);
      chk("b_addr_last", {13'b0, mem_b_addr}, 255);
      goto(3169);
      chk("b_addr_hold", {13'b0, mem_b_addr}, 255);
      goto(3200);
      mode_b = 2'b11;
      mem_a_const = 1'b1;

      // Vertical timing and frame count.
      goto(4002);
      chk("vs_e4002", {31'b0, vs_a}, 1);
      goto(4003);
      chk("vs_e4003", {31'b0, vs_a}, 0);
      chk("vs_b_e4003", {31'b0, vs_b}, 0);
      goto(4162);
      chk("vs_e4162", {31'b0, vs_a}, 0);
      goto(4163);
      chk("vs_e4163", {31'b0, vs_a}, 1);
      goto(4479);
      chk("frame_e4479", {16'h0, frame_a}, 0);
      goto(4480);
      chk("frame_e4480", {16'h0, frame_a}, 1);
      chk("frame_b_e4480", {16'h0, frame_b}, 1);

      // Colour bars in dut_b frame 1 (bar width 8).
      goto(4490);
      chk("bar_white", {8'h0, r_b, g_b, b_b}, 32'hFFFFFF);
      goto(4491);
      chk("bar_yellow", {8'h0, r_b, g_b, b_b}, 32'hFFFF00);
      goto(4523);
      chk("bar_red", {8'h0, r_b, g_b, b_b}, 32'hFF0000);
      goto(4546);
      chk("bar_black", {8'h0, r_b, g_b, b_b}, 0);
      goto(4547);
      chk("bar_blank", {31'b0, blank_b}, 0);

      // Mode change mid-frame 1 takes effect at frame 2.
      goto(5000);
      mode_a = 2'b01;
      goto(6103);
      chk("bar_cyan_img", {8'h0, r_b, g_b, b_b}, 32'h00FFFF);
      goto(6113);
      chk("grey_30", {24'b0, r_a}, 32'h30);
      goto(8960);
      chk("frame_e8960", {16'h0, frame_a}, 2);
      goto(10593);
      chk("invert_cf", {8'h0, r_a, g_a, b_a}, 32'hCFCFCF);
      goto(11000);
      mode_a = 2'b10;
      thr = 8'h30;
      goto(11393);
      chk("invert_hold", {24'b0, r_a}, 32'hCF);
      goto(15073);
      chk("thr_eq", {8'h0, r_a, g_a, b_a}, 32'hFFFFFF);
      goto(16000);
      thr = 8'h31;
      goto(19553);
      chk("thr_above", {24'b0, r_a}, 0);

      // Reset mid-frame at hc=30, vc=20 of frame 5.
      goto(24030);
      chk("pre_rst_blank", {31'b0, blank_a}, 1);
      instr = 32'h0;
      reset = 1'b0;
      #1;
      chk("mid_rst_blank", {31'b0, blank_a}, 0);
      chk("mid_rst_sync", {30'b0, hs_a, vs_a}, 3);
      chk("mid_rst_halted", {31'b0, halted_a}, 0);
      chk("mid_rst_frame", {16'h0, frame_a}, 0);
      chk("mid_rst_addr", {13'b0, mem_a_addr}, 0);
      @(negedge clk);
      reset = 1'b1;
      ecnt = 0;
      goto(2);
      chk("re_blank_e2", {31'b0, blank_a}, 0);
      goto(3);
      chk("re_blank_e3", {31'b0, blank_a}, 1);
      chk("re_ce_e3", {31'b0, proc_ce_a}, 1);
      chk("re_halted", {31'b0, halted_a}, 0);
      goto(70);
      chk("re_hs_e70", {31'b0, hs_a}, 1);
      goto(71);
      chk("re_hs_e71", {31'b0, hs_a}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
